// File: rtl/fpcvt_seq_if.sv
// Handshake bundle for the fixed-to-float converter.
// The producer/consumer side uses the master modport and the converter uses the slave modport.
interface fpcvt_seq_if #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int MW = 4
);
    logic [DW-1:0] D;
    logic          rnd_trunc;
    logic          in_valid;
    logic          in_ready;
    logic          S;
    logic [EW-1:0] E;
    logic [MW-1:0] F;
    logic          sat;
    logic          out_valid;
    logic          out_ready;

    modport master (
        output D, rnd_trunc, in_valid, out_ready,
        input  in_ready, S, E, F, sat, out_valid
    );

    modport slave (
        input  D, rnd_trunc, in_valid, out_ready,
        output in_ready, S, E, F, sat, out_valid
    );
endinterface

// File: rtl/fpcvt_seq.sv
// Sequential two's-complement to small-float converter.
// The converter normalises by one bit per cycle, rounds once, and holds the result until the consumer takes it.
module fpcvt_seq #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int MW = 4
) (
    input logic        clk,
    input logic        rst,
    fpcvt_seq_if.slave bus
);
    localparam int MAGW = DW - 1;
    localparam logic [EW-1:0] EXP_MAX = '1;

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;

    state_t          state_q, state_d;
    logic [MAGW-1:0] mag_q, mag_d;
    logic [EW-1:0]   exp_q, exp_d;
    logic            sign_q, sign_d;
    logic            trunc_q, trunc_d;
    logic            psat_q, psat_d;
    logic            s_q, s_d;
    logic [EW-1:0]   e_q, e_d;
    logic [MW-1:0]   f_q, f_d;
    logic            sat_q, sat_d;
    logic            in_ready_q, in_ready_d;
    logic            out_valid_q, out_valid_d;

    logic [MAGW-1:0] mag_abs;
    logic            most_neg;
    logic [MW-1:0]   f_raw;
    logic            r_bit;
    logic [MW:0]     f_sum;
    logic [EW:0]     exp_inc;

    always_comb begin
        most_neg = (bus.D == {1'b1, {(DW-1){1'b0}}});
        mag_abs  = bus.D[DW-1] ? ((~bus.D[DW-2:0]) + MAGW'(1)) : bus.D[DW-2:0];
        // The most-negative input has no positive counterpart; clamp it and flag saturation.
        if (most_neg) begin
            mag_abs = '1;
        end

        f_raw   = mag_q[MAGW-1 -: MW];
        r_bit   = mag_q[MAGW-1-MW] & ~trunc_q;
        f_sum   = {1'b0, f_raw} + (MW+1)'(r_bit);
        exp_inc = {1'b0, exp_q} + (EW+1)'(1);

        state_d     = state_q;
        mag_d       = mag_q;
        exp_d       = exp_q;
        sign_d      = sign_q;
        trunc_d     = trunc_q;
        psat_d      = psat_q;
        s_d         = s_q;
        e_d         = e_q;
        f_d         = f_q;
        sat_d       = sat_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    sign_d     = bus.D[DW-1];
                    trunc_d    = bus.rnd_trunc;
                    mag_d      = mag_abs;
                    psat_d     = most_neg;
                    exp_d      = EXP_MAX;
                    in_ready_d = 1'b0;
                    state_d    = NORM;
                end
            end
            NORM: begin
                if (mag_q[MAGW-1] || (exp_q == '0)) begin
                    state_d = ROUND;
                end else begin
                    mag_d = mag_q << 1;
                    exp_d = exp_q - EW'(1);
                end
            end
            ROUND: begin
                s_d = sign_q;
                // A rounding carry out of the top exponent means the value no longer fits.
                if (psat_q || (f_sum[MW] && exp_inc[EW])) begin
                    e_d   = '1;
                    f_d   = '1;
                    sat_d = 1'b1;
                end else if (f_sum[MW]) begin
                    e_d   = exp_inc[EW-1:0];
                    f_d   = {1'b1, {(MW-1){1'b0}}};
                    sat_d = 1'b0;
                end else begin
                    e_d   = exp_q;
                    f_d   = f_sum[MW-1:0];
                    sat_d = 1'b0;
                end
                out_valid_d = 1'b1;
                state_d     = DONE;
            end
            DONE: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            mag_q       <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            trunc_q     <= 1'b0;
            psat_q      <= 1'b0;
            s_q         <= 1'b0;
            e_q         <= '0;
            f_q         <= '0;
            sat_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            mag_q       <= mag_d;
            exp_q       <= exp_d;
            sign_q      <= sign_d;
            trunc_q     <= trunc_d;
            psat_q      <= psat_d;
            s_q         <= s_d;
            e_q         <= e_d;
            f_q         <= f_d;
            sat_q       <= sat_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.S         = s_q;
    assign bus.E         = e_q;
    assign bus.F         = f_q;
    assign bus.sat       = sat_q;
endmodule

// File: tb/tb_fpcvt_seq.sv
// Scoreboard bench for fpcvt_seq: directed vectors with known results plus random samples checked against an arithmetic model.
module tb_fpcvt_seq;
    logic clk;
    logic rst;

    fpcvt_seq_if #(.DW(12), .EW(3), .MW(4)) bus();

    fpcvt_seq #(.DW(12), .EW(3), .MW(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic       s;
        logic [2:0] e;
        logic [3:0] f;
        logic       sat;
        int         k;
    } exp_t;

    exp_t sb[$];
    int   compared;
    int   mismatched;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Every comparison in the bench goes through here.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input logic s, input logic [2:0] e, input logic [3:0] f,
                                input logic sat, input int k);
        exp_t x;
        x.s = s; x.e = e; x.f = f; x.sat = sat; x.k = k;
        return x;
    endfunction

    // Arithmetic reference: scale the magnitude up to the top bit, then round on the bit below the significand.
    function automatic exp_t model(input logic [11:0] d, input logic m);
        exp_t x;
        int mag, norm, k, f, r, e;
        logic ovf;
        mag = d[11] ? (4096 - int'(d)) : int'(d);
        ovf = (mag > 2047);
        if (ovf) mag = 2047;
        norm = mag;
        k = 0;
        while (k < 7 && norm < 1024) begin
            norm = norm * 2;
            k++;
        end
        f = (norm / 128) % 16;
        r = (norm / 64) % 2;
        e = 7 - k;
        if (!m && r == 1) f = f + 1;
        if (f == 16) begin
            f = 8;
            e = e + 1;
        end
        x.s   = d[11];
        x.k   = k;
        x.sat = ovf || (e > 7);
        x.e   = x.sat ? 3'd7 : 3'(e);
        x.f   = x.sat ? 4'hF : 4'(f);
        return x;
    endfunction

    task automatic applyStimulus(input logic [11:0] d, input logic m, input exp_t want, input int hold);
        exp_t ex;
        int   edges;
        bit   seen;
        @(negedge clk);
        checkOutput("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.D         = d;
        bus.rnd_trunc = m;
        bus.in_valid  = 1'b1;
        sb.push_back(want);
        @(posedge clk);
        #1;
        bus.in_valid  = 1'b0;
        bus.D         = 12'($urandom);
        bus.rnd_trunc = 1'($urandom);
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 20) begin
            @(posedge clk);
            edges++;
            #1;
            if (bus.out_valid) seen = 1'b1;
            else checkOutput("in_ready_busy", 32'(bus.in_ready), 32'd0);
        end
        ex = sb.pop_front();
        if (!seen) begin
            checkOutput("out_valid_timeout", 32'd0, 32'd1);
        end else begin
            checkOutput("latency", 32'(edges), 32'(ex.k + 2));
        end
        for (int i = 0; i <= hold; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
                checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
                checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
            end
            checkOutput("S", 32'(bus.S), 32'(ex.s));
            checkOutput("E", 32'(bus.E), 32'(ex.e));
            checkOutput("F", 32'(bus.F), 32'(ex.f));
            checkOutput("sat", 32'(bus.sat), 32'(ex.sat));
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        checkOutput("in_ready_after", 32'(bus.in_ready), 32'd1);
        checkOutput("out_valid_after", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        int         ov_count;
        logic [11:0] rd;
        logic        rm;
        compared      = 0;
        mismatched    = 0;
        rst           = 1'b1;
        bus.D         = '0;
        bus.rnd_trunc = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("rst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("rst_S", 32'(bus.S), 32'd0);
        checkOutput("rst_E", 32'(bus.E), 32'd0);
        checkOutput("rst_F", 32'(bus.F), 32'd0);
        checkOutput("rst_sat", 32'(bus.sat), 32'd0);

        applyStimulus(12'h069, 1'b0, mk(1'b0, 3'd3, 4'hD, 1'b0, 4), 0);
        applyStimulus(12'h07D, 1'b0, mk(1'b0, 3'd4, 4'h8, 1'b0, 4), 5);
        applyStimulus(12'h1FF, 1'b0, mk(1'b0, 3'd6, 4'h8, 1'b0, 2), 0);
        applyStimulus(12'h1FF, 1'b1, mk(1'b0, 3'd5, 4'hF, 1'b0, 2), 1);
        applyStimulus(12'h7FF, 1'b0, mk(1'b0, 3'd7, 4'hF, 1'b1, 0), 0);
        applyStimulus(12'h800, 1'b0, mk(1'b1, 3'd7, 4'hF, 1'b1, 0), 0);
        applyStimulus(12'h800, 1'b1, mk(1'b1, 3'd7, 4'hF, 1'b1, 0), 0);
        applyStimulus(12'h7FF, 1'b1, mk(1'b0, 3'd7, 4'hF, 1'b0, 0), 0);
        applyStimulus(12'hFFF, 1'b0, mk(1'b1, 3'd0, 4'h1, 1'b0, 7), 0);
        applyStimulus(12'h000, 1'b0, mk(1'b0, 3'd0, 4'h0, 1'b0, 7), 2);

        // Reset lands in the second NORM cycle of a long conversion.
        @(negedge clk);
        bus.D        = 12'h001;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        checkOutput("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        checkOutput("midrst_S", 32'(bus.S), 32'd0);
        checkOutput("midrst_E", 32'(bus.E), 32'd0);
        checkOutput("midrst_F", 32'(bus.F), 32'd0);
        ov_count = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) ov_count++;
        end
        checkOutput("midrst_no_valid", 32'(ov_count), 32'd0);
        applyStimulus(12'h163, 1'b0, mk(1'b0, 3'd5, 4'hB, 1'b0, 2), 0);

        for (int i = 0; i < 24; i++) begin
            rd = 12'($urandom);
            rm = 1'($urandom);
            applyStimulus(rd, rm, model(rd, rm), int'($urandom_range(0, 2)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
